// File: rtl/move_gen_sequencer_pkg.sv
// rtl/move_gen_sequencer_pkg.sv - piece/state encodings and ray-direction tables for the move generator
package move_gen_sequencer_pkg;

  typedef enum logic [2:0] {
    PT_EMPTY   = 3'd0,
    PT_PAWN    = 3'd1,
    PT_KNIGHT  = 3'd2,
    PT_BISHOP  = 3'd3,
    PT_ROOK    = 3'd4,
    PT_QUEEN   = 3'd5,
    PT_KING    = 3'd6,
    PT_INVALID = 3'd7
  } ptype_e;

  localparam logic WHITE = 1'b0;
  localparam logic BLACK = 1'b1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_SRC_RD,
    S_SRC_CHK,
    S_NEXT_SRC,
    S_DIR_INIT,
    S_DST_RD,
    S_DST_CHK,
    S_EMIT,
    S_NEXT_DIR,
    S_DONE
  } state_e;

  typedef struct packed {
    ptype_e     ptype;
    logic [2:0] col;
    logic [2:0] row;
    logic       color;
  } piece_t;

  typedef struct packed {
    logic signed [1:0] dcol;
    logic signed [1:0] drow;
  } dir_t;

  // Zero means the piece type is not generated here (empty, knight, invalid).
  function automatic logic [3:0] dir_count(input ptype_e t);
    case (t)
      PT_PAWN:             return 4'd3;
      PT_ROOK, PT_BISHOP:  return 4'd4;
      PT_QUEEN, PT_KING:   return 4'd8;
      default:             return 4'd0;
    endcase
  endfunction

  function automatic logic [2:0] dir_range(input ptype_e t, input logic [2:0] idx);
    case (t)
      PT_PAWN: return (idx == 3'd0) ? 3'd2 : 3'd1;
      PT_KING: return 3'd1;
      default: return 3'd7;
    endcase
  endfunction

  // Shared table: entries 0-3 orthogonal, 4-7 diagonal; pawns use forward, fwd+col, fwd-col.
  function automatic dir_t dir_lookup(input ptype_e t, input logic color, input logic [2:0] idx);
    dir_t       d;
    logic [2:0] k;
    k = (t == PT_BISHOP) ? (idx + 3'd4) : idx;
    case (k)
      3'd0:    begin d.dcol = 2'sb00; d.drow = 2'sb01; end
      3'd1:    begin d.dcol = 2'sb01; d.drow = 2'sb00; end
      3'd2:    begin d.dcol = 2'sb00; d.drow = 2'sb11; end
      3'd3:    begin d.dcol = 2'sb11; d.drow = 2'sb00; end
      3'd4:    begin d.dcol = 2'sb01; d.drow = 2'sb01; end
      3'd5:    begin d.dcol = 2'sb01; d.drow = 2'sb11; end
      3'd6:    begin d.dcol = 2'sb11; d.drow = 2'sb11; end
      default: begin d.dcol = 2'sb11; d.drow = 2'sb01; end
    endcase
    if (t == PT_PAWN) begin
      d.drow = (color == WHITE) ? 2'sb01 : 2'sb11;
      d.dcol = (idx == 3'd0) ? 2'sb00 : ((idx == 3'd1) ? 2'sb01 : 2'sb11);
    end
    return d;
  endfunction

  // Returns {off_board, col, row}; bit 3 of either 4-bit sum flags leaving 0..7.
  function automatic logic [6:0] step_sq(input logic [5:0] sq, input dir_t d);
    logic [3:0] c;
    logic [3:0] r;
    c = {1'b0, sq[5:3]} + {{2{d.dcol[1]}}, d.dcol};
    r = {1'b0, sq[2:0]} + {{2{d.drow[1]}}, d.drow};
    return {c[3] | r[3], c[2:0], r[2:0]};
  endfunction

endpackage

// File: rtl/move_gen_sequencer_if.sv
// rtl/move_gen_sequencer_if.sv - control, board-read and move-stream bundle of the move generator
interface move_gen_sequencer_if #(
  parameter int CNT_W = 8
);
  logic             start;
  logic             turn;
  logic [5:0]       sq_addr;
  logic [9:0]       sq_data;
  logic             move_valid;
  logic             move_ready;
  logic [15:0]      move_data;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] move_count;

  modport master (
    input  start, turn, sq_data, move_ready,
    output sq_addr, move_valid, move_data, busy, done, move_count
  );

  modport slave (
    output start, turn, sq_data, move_ready,
    input  sq_addr, move_valid, move_data, busy, done, move_count
  );
endinterface

// File: rtl/move_gen_sequencer_checker.sv
// rtl/move_gen_sequencer_checker.sv - combinational legality check and formatting of one (src,dest) pair
module move_gen_sequencer_checker
  import move_gen_sequencer_pkg::*;
(
  input  piece_t      src_piece_i,
  input  piece_t      dst_piece_i,
  input  logic        turn_i,
  output logic        valid_o,
  output logic        slide_valid_o,
  output logic [15:0] formatted_move_o
);
  logic own_src;
  logic dst_empty;
  logic dst_enemy;
  logic is_pawn;
  logic pawn_fwd;
  logic start_rank;

  assign own_src    = (dir_count(src_piece_i.ptype) != 4'd0) && (src_piece_i.color == turn_i);
  assign dst_empty  = dst_piece_i.ptype == PT_EMPTY;
  assign dst_enemy  = !dst_empty && (dst_piece_i.ptype != PT_INVALID) && (dst_piece_i.color != turn_i);
  assign is_pawn    = src_piece_i.ptype == PT_PAWN;
  assign pawn_fwd   = src_piece_i.col == dst_piece_i.col;
  assign start_rank = (turn_i == WHITE) ? (src_piece_i.row == 3'd1) : (src_piece_i.row == 3'd6);

  // Pawns push only onto empty squares and capture only diagonally; double push only from the home rank.
  assign valid_o = own_src && (is_pawn ? (pawn_fwd ? dst_empty : dst_enemy) : (dst_empty || dst_enemy));
  assign slide_valid_o = valid_o && dst_empty && (!is_pawn || start_rank);

  assign formatted_move_o = {dst_enemy, src_piece_i.col, src_piece_i.row,
                             dst_piece_i.col, dst_piece_i.row, src_piece_i.ptype};
endmodule

// File: rtl/move_gen_sequencer.sv
// rtl/move_gen_sequencer.sv - scans the board, walks each own piece's rays and streams accepted moves
module move_gen_sequencer
  import move_gen_sequencer_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  move_gen_sequencer_if.master bus
);
  state_e           state_q, state_d;
  logic [5:0]       src_idx_q, src_idx_d;
  logic [2:0]       dir_idx_q, dir_idx_d;
  logic [2:0]       step_q, step_d;
  logic [5:0]       cur_sq_q, cur_sq_d;
  piece_t           src_piece_q, src_piece_d;
  logic [15:0]      move_data_q, move_data_d;
  logic [CNT_W-1:0] move_count_q, move_count_d;
  logic             turn_q, turn_d;
  logic             slide_q, slide_d;

  piece_t     rd_piece;
  dir_t       cur_dir;
  logic [3:0] cur_count;
  logic [2:0] cur_range;
  logic [5:0] step_base;
  logic [6:0] step_nxt;
  logic       src_ok;
  logic       chk_valid;
  logic       chk_slide;
  logic [15:0] chk_move;

  assign rd_piece  = piece_t'(bus.sq_data);
  assign src_ok    = (dir_count(rd_piece.ptype) != 4'd0) && (rd_piece.color == turn_q);
  assign cur_dir   = dir_lookup(src_piece_q.ptype, src_piece_q.color, dir_idx_q);
  assign cur_count = dir_count(src_piece_q.ptype);
  assign cur_range = dir_range(src_piece_q.ptype, dir_idx_q);
  assign step_base = (state_q == S_DIR_INIT) ? src_idx_q : cur_sq_q;
  assign step_nxt  = step_sq(step_base, cur_dir);

  move_gen_sequencer_checker u_checker (
    .src_piece_i      (src_piece_q),
    .dst_piece_i      (rd_piece),
    .turn_i           (turn_q),
    .valid_o          (chk_valid),
    .slide_valid_o    (chk_slide),
    .formatted_move_o (chk_move)
  );

  always_comb begin
    state_d      = state_q;
    src_idx_d    = src_idx_q;
    dir_idx_d    = dir_idx_q;
    step_d       = step_q;
    cur_sq_d     = cur_sq_q;
    src_piece_d  = src_piece_q;
    move_data_d  = move_data_q;
    move_count_d = move_count_q;
    turn_d       = turn_q;
    slide_d      = slide_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d      = S_SRC_RD;
          src_idx_d    = 6'd0;
          move_count_d = '0;
          turn_d       = bus.turn;
        end
      end
      S_SRC_RD: state_d = S_SRC_CHK;
      S_SRC_CHK: begin
        src_piece_d = rd_piece;
        dir_idx_d   = 3'd0;
        // Skipped squares bypass NEXT_SRC so an empty/foreign square costs only two cycles.
        if (src_ok) begin
          state_d = S_DIR_INIT;
        end else if (src_idx_q == 6'd63) begin
          state_d = S_DONE;
        end else begin
          src_idx_d = src_idx_q + 6'd1;
          state_d   = S_SRC_RD;
        end
      end
      S_DIR_INIT: begin
        step_d   = 3'd1;
        cur_sq_d = step_nxt[5:0];
        state_d  = step_nxt[6] ? S_NEXT_DIR : S_DST_RD;
      end
      S_DST_RD: state_d = S_DST_CHK;
      S_DST_CHK: begin
        if (chk_valid) begin
          move_data_d = chk_move;
          slide_d     = chk_slide;
          state_d     = S_EMIT;
        end else begin
          state_d = S_NEXT_DIR;
        end
      end
      S_EMIT: begin
        if (bus.move_ready) begin
          if (move_count_q != {CNT_W{1'b1}}) begin
            move_count_d = move_count_q + CNT_W'(1);
          end
          if (slide_q && (step_q < cur_range)) begin
            step_d   = step_q + 3'd1;
            cur_sq_d = step_nxt[5:0];
            state_d  = step_nxt[6] ? S_NEXT_DIR : S_DST_RD;
          end else begin
            state_d = S_NEXT_DIR;
          end
        end
      end
      S_NEXT_DIR: begin
        if (({1'b0, dir_idx_q} + 4'd1) == cur_count) begin
          state_d = S_NEXT_SRC;
        end else begin
          dir_idx_d = dir_idx_q + 3'd1;
          state_d   = S_DIR_INIT;
        end
      end
      S_NEXT_SRC: begin
        if (src_idx_q == 6'd63) begin
          state_d = S_DONE;
        end else begin
          src_idx_d = src_idx_q + 6'd1;
          state_d   = S_SRC_RD;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      src_idx_q    <= '0;
      dir_idx_q    <= '0;
      step_q       <= '0;
      cur_sq_q     <= '0;
      src_piece_q  <= '0;
      move_data_q  <= '0;
      move_count_q <= '0;
      turn_q       <= 1'b0;
      slide_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      src_idx_q    <= src_idx_d;
      dir_idx_q    <= dir_idx_d;
      step_q       <= step_d;
      cur_sq_q     <= cur_sq_d;
      src_piece_q  <= src_piece_d;
      move_data_q  <= move_data_d;
      move_count_q <= move_count_d;
      turn_q       <= turn_d;
      slide_q      <= slide_d;
    end
  end

  // EMIT keeps the destination address so the RAM output stays on the target square.
  assign bus.sq_addr    = ((state_q == S_DST_RD) || (state_q == S_DST_CHK) || (state_q == S_EMIT))
                          ? cur_sq_q : src_idx_q;
  assign bus.move_valid = state_q == S_EMIT;
  assign bus.move_data  = move_data_q;
  assign bus.move_count = move_count_q;
  assign bus.busy       = (state_q != S_IDLE) && (state_q != S_DONE);
  assign bus.done       = state_q == S_DONE;
endmodule

// File: tb/tb_move_gen_sequencer.sv
// tb/tb_move_gen_sequencer.sv - directed self-checking bench for move_gen_sequencer
module tb_move_gen_sequencer;
  import move_gen_sequencer_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  move_gen_sequencer_if #(.CNT_W(8)) bus ();
  move_gen_sequencer #(.CNT_W(8)) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  logic [9:0] board [64];
  always @(posedge clk) bus.sq_data <= board[bus.sq_addr];

  int          n_checks = 0;
  int          n_pass = 0;
  logic [15:0] moves [$];
  int          scan_done;
  int          scan_cycles;
  int          stall_bad;
  logic        valid_seen;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
  endtask

  function automatic logic [15:0] fmt(input logic cap, input logic [5:0] src, input logic [5:0] dst,
                                      input logic [2:0] t);
    return {cap, src, dst, t};
  endfunction

  task automatic clear_board();
    for (int i = 0; i < 64; i++) begin
      logic [5:0] s;
      s = 6'(i);
      board[i] = {3'd0, s, 1'b0};
    end
  endtask

  task automatic place(input logic [5:0] sq, input logic [2:0] t, input logic color);
    board[sq] = {t, sq, color};
  endtask

  function automatic int n_captures();
    int n = 0;
    foreach (moves[i]) if (moves[i][15]) n++;
    return n;
  endfunction

  function automatic int n_with(input logic [15:0] mv);
    int n = 0;
    foreach (moves[i]) if (moves[i] == mv) n++;
    return n;
  endfunction

  function automatic int n_to(input logic [5:0] dst);
    int n = 0;
    foreach (moves[i]) if (moves[i][8:3] == dst) n++;
    return n;
  endfunction

  task automatic run_scan(input logic side, input bit stall);
    int          hold;
    bit          stalled;
    logic [15:0] held;
    moves.delete();
    scan_done = 0; scan_cycles = 0; stall_bad = 0; valid_seen = 1'b0;
    hold = 0; stalled = 1'b0; held = '0;
    bus.move_ready = 1'b1;
    @(negedge clk); bus.start = 1'b1; bus.turn = side;
    @(negedge clk); bus.start = 1'b0; bus.turn = ~side;
    while (scan_done == 0 && scan_cycles < 3000) begin
      scan_cycles++;
      if (bus.move_valid) valid_seen = 1'b1;
      if (bus.done) scan_done++;
      if (stall && !stalled && bus.move_valid) begin
        stalled = 1'b1; hold = 10; held = bus.move_data; bus.move_ready = 1'b0;
      end else if (hold > 0) begin
        if (!bus.move_valid || bus.move_data != held || bus.move_count != 8'd0) stall_bad++;
        hold--;
        if (hold == 0) bus.move_ready = 1'b1;
      end
      if (bus.move_valid && bus.move_ready) moves.push_back(bus.move_data);
      @(negedge clk);
    end
    repeat (4) begin
      if (bus.done) scan_done++;
      @(negedge clk);
    end
  endtask

  initial begin
    rst_n = 1'b0; bus.start = 1'b0; bus.turn = 1'b0; bus.move_ready = 1'b0;
    clear_board();
    repeat (3) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_valid", bus.move_valid, 0);
    check("rst_count", bus.move_count, 0);
    check("rst_data", bus.move_data, 0);
    check("rst_addr", bus.sq_addr, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Lone white rook on a1
    place(6'o00, 3'd4, WHITE);
    run_scan(WHITE, 1'b0);
    check("t1_moves", moves.size(), 14);
    check("t1_count", bus.move_count, 14);
    check("t1_captures", n_captures(), 0);
    check("t1_done_pulses", scan_done, 1);
    check("t1_first", moves.size() > 0 ? moves[0] : 16'hFFFF, fmt(0, 6'o00, 6'o01, 3'd4));
    check("t1_busy_after", bus.busy, 0);

    // White pawn e2 on empty board
    clear_board();
    place(6'o41, 3'd1, WHITE);
    run_scan(WHITE, 1'b0);
    check("t2a_moves", moves.size(), 2);
    check("t2a_e3", n_with(fmt(0, 6'o41, 6'o42, 3'd1)), 1);
    check("t2a_e4", n_with(fmt(0, 6'o41, 6'o43, 3'd1)), 1);

    place(6'o42, 3'd2, BLACK);
    run_scan(WHITE, 1'b0);
    check("t2b_blocked", moves.size(), 0);
    check("t2b_count", bus.move_count, 0);

    place(6'o42, 3'd0, WHITE);
    place(6'o32, 3'd2, BLACK);
    place(6'o52, 3'd2, BLACK);
    run_scan(WHITE, 1'b0);
    check("t2c_moves", moves.size(), 4);
    check("t2c_captures", n_captures(), 2);
    check("t2c_xd3", n_with(fmt(1, 6'o41, 6'o32, 3'd1)), 1);
    check("t2c_xf3", n_with(fmt(1, 6'o41, 6'o52, 3'd1)), 1);

    // Rook a1 blocked by black bishop on a3
    clear_board();
    place(6'o00, 3'd4, WHITE);
    place(6'o02, 3'd3, BLACK);
    run_scan(WHITE, 1'b0);
    check("t3_moves", moves.size(), 9);
    check("t3_capture_a3", n_with(fmt(1, 6'o00, 6'o02, 3'd4)), 1);
    check("t3_no_a4", n_to(6'o03), 0);
    check("t3_count", bus.move_count, 9);

    // Backpressure on the first move
    clear_board();
    place(6'o00, 3'd4, WHITE);
    run_scan(WHITE, 1'b1);
    check("t4_stall_stable", stall_bad, 0);
    check("t4_moves", moves.size(), 14);
    check("t4_count", bus.move_count, 14);
    check("t4_first", moves.size() > 0 ? moves[0] : 16'hFFFF, fmt(0, 6'o00, 6'o01, 3'd4));

    // Black to move with only white pieces
    place(6'o41, 3'd1, WHITE);
    run_scan(BLACK, 1'b0);
    check("t5_within_140", scan_cycles <= 140, 1);
    check("t5_count", bus.move_count, 0);
    check("t5_no_valid", valid_seen, 0);
    check("t5_done_pulses", scan_done, 1);

    // Reset in the middle of a scan
    clear_board();
    place(6'o00, 3'd4, WHITE);
    bus.move_ready = 1'b1;
    @(negedge clk); bus.start = 1'b1; bus.turn = WHITE;
    @(negedge clk); bus.start = 1'b0;
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("t6_busy", bus.busy, 0);
    check("t6_valid", bus.move_valid, 0);
    check("t6_count", bus.move_count, 0);
    scan_done = 0;
    repeat (200) begin
      if (bus.done || bus.busy) scan_done++;
      @(negedge clk);
    end
    check("t6_no_done", scan_done, 0);
    run_scan(WHITE, 1'b0);
    check("t6_rescan_moves", moves.size(), 14);
    check("t6_rescan_count", bus.move_count, 14);
    check("t6_rescan_done", scan_done, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
